// File: rtl/exe_stage_pkg.sv
// Shared op codes, divider state encoding and constants for the execute stage.
package exe_stage_pkg;

    typedef enum logic [5:0] {
        EXE_NOP_OP   = 6'h00,
        EXE_AND_OP   = 6'h01,
        EXE_OR_OP    = 6'h02,
        EXE_XOR_OP   = 6'h03,
        EXE_NOR_OP   = 6'h04,
        EXE_ADD_OP   = 6'h05,
        EXE_ADDU_OP  = 6'h06,
        EXE_SUB_OP   = 6'h07,
        EXE_SUBU_OP  = 6'h08,
        EXE_SLT_OP   = 6'h09,
        EXE_SLTU_OP  = 6'h0A,
        EXE_SLL_OP   = 6'h0B,
        EXE_SRL_OP   = 6'h0C,
        EXE_SRA_OP   = 6'h0D,
        EXE_SLLV_OP  = 6'h0E,
        EXE_SRLV_OP  = 6'h0F,
        EXE_SRAV_OP  = 6'h10,
        EXE_LUI_OP   = 6'h11,
        EXE_JAL_OP   = 6'h12,
        EXE_JALR_OP  = 6'h13,
        EXE_MFHI_OP  = 6'h14,
        EXE_MFLO_OP  = 6'h15,
        EXE_MTHI_OP  = 6'h16,
        EXE_MTLO_OP  = 6'h17,
        EXE_MULT_OP  = 6'h18,
        EXE_MULTU_OP = 6'h19,
        EXE_DIV_OP   = 6'h1A,
        EXE_DIVU_OP  = 6'h1B
    } exe_op_e;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

    localparam logic [31:0] ZERO_WORD    = 32'h0000_0000;
    localparam logic [4:0]  NOP_REG_ADDR = 5'd0;

endpackage

// File: rtl/serial_div.sv
// Restoring shift-subtract divider, one quotient bit per cycle, signed or unsigned.
// Only compiled into the design when EXE_DIV_EN is defined.
`ifdef EXE_DIV_EN
module serial_div
    import exe_stage_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int DIV_CYC = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              signed_op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] quot,
    output logic [DATA_W-1:0] rem
);

    localparam int CNT_W = $clog2(DIV_CYC);

    div_state_e        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_rem;
    logic [DATA_W-1:0] r_quot;
    logic [DATA_W-1:0] r_div;
    logic              r_qneg;
    logic              r_rneg;

    logic [DATA_W-1:0] w_a_mag;
    logic [DATA_W-1:0] w_b_mag;
    logic [DATA_W:0]   w_shift;
    logic [DATA_W+1:0] w_diff;

    assign w_a_mag = (signed_op && a[DATA_W-1]) ? (~a + 1'b1) : a;
    assign w_b_mag = (signed_op && b[DATA_W-1]) ? (~b + 1'b1) : b;

    // Dividend bits shift out of r_quot into the partial remainder as quotient bits shift in.
    assign w_shift = {r_rem, r_quot[DATA_W-1]};
    assign w_diff  = {1'b0, w_shift} - {2'b00, r_div};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= DIV_IDLE;
            r_cnt   <= '0;
            r_rem   <= '0;
            r_quot  <= '0;
            r_div   <= '0;
            r_qneg  <= 1'b0;
            r_rneg  <= 1'b0;
        end else begin
            case (r_state)
                DIV_IDLE: begin
                    if (start) begin
                        r_quot  <= w_a_mag;
                        r_rem   <= '0;
                        r_div   <= w_b_mag;
                        // Divide-by-zero keeps the all-ones quotient, so no negation there.
                        r_qneg  <= signed_op && (a[DATA_W-1] ^ b[DATA_W-1]) && (|b);
                        r_rneg  <= signed_op && a[DATA_W-1];
                        r_cnt   <= '0;
                        r_state <= DIV_BUSY;
                    end
                end
                DIV_BUSY: begin
                    if (w_diff[DATA_W+1]) begin
                        r_rem  <= w_shift[DATA_W-1:0];
                        r_quot <= {r_quot[DATA_W-2:0], 1'b0};
                    end else begin
                        r_rem  <= w_diff[DATA_W-1:0];
                        r_quot <= {r_quot[DATA_W-2:0], 1'b1};
                    end
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CNT_W'(DIV_CYC - 1))
                        r_state <= DIV_DONE;
                end
                DIV_DONE: r_state <= DIV_IDLE;
                default:  r_state <= DIV_IDLE;
            endcase
        end
    end

    assign busy = rst && (((r_state == DIV_IDLE) && start) || (r_state == DIV_BUSY));
    assign done = (r_state == DIV_DONE);
    assign quot = r_qneg ? (~r_quot + 1'b1) : r_quot;
    assign rem  = r_rneg ? (~r_rem + 1'b1) : r_rem;

endmodule
`endif

// File: rtl/exe_stage.sv
// Execute stage: combinational GPR result, HI/LO ownership, single-cycle multiply,
// and an optional serial divider enabled with the EXE_DIV_EN macro.
module exe_stage
    import exe_stage_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int DIV_CYC = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [5:0]        exe_aluop,
    input  logic [DATA_W-1:0] exe_reg_1,
    input  logic [DATA_W-1:0] exe_reg_2,
    input  logic [31:0]       exe_inst,
    input  logic [4:0]        exe_write_reg,
    input  logic              exe_we,
    input  logic [DATA_W-1:0] exe_link_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [4:0]        mem_write_reg,
    output logic              mem_we,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o,
    output logic              stall_req
);

    if (DATA_W != 32 || DIV_CYC != DATA_W) begin : g_bad_cfg
        $error("exe_stage: only DATA_W=32 with DIV_CYC=DATA_W is supported");
    end

    logic [DATA_W-1:0]   r_hi;
    logic [DATA_W-1:0]   r_lo;
    logic [DATA_W-1:0]   w_result;
    logic                w_gpr_op;
    logic [4:0]          w_shamt;
    logic [4:0]          w_vshamt;
    logic [2*DATA_W-1:0] w_prod_s;
    logic [2*DATA_W-1:0] w_prod_u;
    logic                w_div_done;
    logic [DATA_W-1:0]   w_div_quot;
    logic [DATA_W-1:0]   w_div_rem;
    logic                w_unused_inst;

    assign w_shamt       = exe_inst[10:6];
    assign w_vshamt      = exe_reg_1[4:0];
    assign w_unused_inst = ^{exe_inst[31:11], exe_inst[5:0]};

    assign w_prod_s = $signed({{DATA_W{exe_reg_1[DATA_W-1]}}, exe_reg_1}) *
                      $signed({{DATA_W{exe_reg_2[DATA_W-1]}}, exe_reg_2});
    assign w_prod_u = {{DATA_W{1'b0}}, exe_reg_1} * {{DATA_W{1'b0}}, exe_reg_2};

    always_comb begin
        w_result = ZERO_WORD;
        w_gpr_op = 1'b1;
        case (exe_aluop)
            EXE_AND_OP:               w_result = exe_reg_1 & exe_reg_2;
            EXE_OR_OP:                w_result = exe_reg_1 | exe_reg_2;
            EXE_XOR_OP:               w_result = exe_reg_1 ^ exe_reg_2;
            EXE_NOR_OP:               w_result = ~(exe_reg_1 | exe_reg_2);
            EXE_ADD_OP, EXE_ADDU_OP:  w_result = exe_reg_1 + exe_reg_2;
            EXE_SUB_OP, EXE_SUBU_OP:  w_result = exe_reg_1 - exe_reg_2;
            EXE_SLT_OP:               w_result[0] = $signed(exe_reg_1) < $signed(exe_reg_2);
            EXE_SLTU_OP:              w_result[0] = exe_reg_1 < exe_reg_2;
            EXE_SLL_OP:               w_result = exe_reg_2 << w_shamt;
            EXE_SRL_OP:               w_result = exe_reg_2 >> w_shamt;
            EXE_SRA_OP:               w_result = $signed(exe_reg_2) >>> w_shamt;
            EXE_SLLV_OP:              w_result = exe_reg_2 << w_vshamt;
            EXE_SRLV_OP:              w_result = exe_reg_2 >> w_vshamt;
            EXE_SRAV_OP:              w_result = $signed(exe_reg_2) >>> w_vshamt;
            EXE_LUI_OP:               w_result = {exe_reg_2[15:0], 16'h0000};
            EXE_JAL_OP, EXE_JALR_OP:  w_result = exe_link_addr;
            EXE_MFHI_OP:              w_result = r_hi;
            EXE_MFLO_OP:              w_result = r_lo;
            // NOP, HI/LO writers, divides and unknown codes never write a GPR.
            default:                  w_gpr_op = 1'b0;
        endcase
    end

    assign mem_wdata     = rst ? w_result : ZERO_WORD;
    assign mem_we        = rst & exe_we & w_gpr_op;
    assign mem_write_reg = exe_write_reg;

`ifdef EXE_DIV_EN
    logic w_div_busy;

    serial_div #(
        .DATA_W  (DATA_W),
        .DIV_CYC (DIV_CYC)
    ) u_div (
        .clk       (clk),
        .rst       (rst),
        .start     ((exe_aluop == EXE_DIV_OP) || (exe_aluop == EXE_DIVU_OP)),
        .signed_op (exe_aluop == EXE_DIV_OP),
        .a         (exe_reg_1),
        .b         (exe_reg_2),
        .busy      (w_div_busy),
        .done      (w_div_done),
        .quot      (w_div_quot),
        .rem       (w_div_rem)
    );

    assign stall_req = w_div_busy;
`else
    assign w_div_done = 1'b0;
    assign w_div_quot = ZERO_WORD;
    assign w_div_rem  = ZERO_WORD;
    assign stall_req  = 1'b0;
`endif

    // Divider completion has priority over any HI/LO write in the same cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hi <= ZERO_WORD;
            r_lo <= ZERO_WORD;
        end else if (w_div_done) begin
            r_hi <= w_div_rem;
            r_lo <= w_div_quot;
        end else begin
            case (exe_aluop)
                EXE_MULT_OP:  {r_hi, r_lo} <= w_prod_s;
                EXE_MULTU_OP: {r_hi, r_lo} <= w_prod_u;
                EXE_MTHI_OP:  r_hi <= exe_reg_1;
                EXE_MTLO_OP:  r_lo <= exe_reg_1;
                default: ;
            endcase
        end
    end

    assign hi_o = r_hi;
    assign lo_o = r_lo;

endmodule

// File: tb/tb_exe_stage.sv
// Directed self-checking bench for exe_stage; divider scenarios run when EXE_DIV_EN is defined.
module tb_exe_stage;
    import exe_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  exe_aluop;
    logic [31:0] exe_reg_1, exe_reg_2, exe_inst, exe_link_addr;
    logic [4:0]  exe_write_reg;
    logic        exe_we;
    logic [31:0] mem_wdata, hi_o, lo_o;
    logic [4:0]  mem_write_reg;
    logic        mem_we, stall_req;

    int n_tests = 0;
    int n_fail  = 0;

    exe_stage dut (
        .clk           (clk),
        .rst           (rst),
        .exe_aluop     (exe_aluop),
        .exe_reg_1     (exe_reg_1),
        .exe_reg_2     (exe_reg_2),
        .exe_inst      (exe_inst),
        .exe_write_reg (exe_write_reg),
        .exe_we        (exe_we),
        .exe_link_addr (exe_link_addr),
        .mem_wdata     (mem_wdata),
        .mem_write_reg (mem_write_reg),
        .mem_we        (mem_we),
        .hi_o          (hi_o),
        .lo_o          (lo_o),
        .stall_req     (stall_req)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic [5:0] op, input logic [31:0] r1, input logic [31:0] r2,
                         input logic we);
        exe_aluop = op;
        exe_reg_1 = r1;
        exe_reg_2 = r2;
        exe_we    = we;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        exe_inst = 32'h0; exe_write_reg = 5'd0; exe_link_addr = 32'h0;
        drive(EXE_ADD_OP, 32'h1, 32'h2, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        n_tests++; if (hi_o !== 32'h0) begin n_fail++; $display("FAIL reset_hi: got %h want 0", hi_o); end
        n_tests++; if (lo_o !== 32'h0) begin n_fail++; $display("FAIL reset_lo: got %h want 0", lo_o); end
        n_tests++; if (stall_req !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", stall_req); end
        n_tests++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b want 0", mem_we); end
        n_tests++; if (mem_wdata !== 32'h0) begin n_fail++; $display("FAIL reset_wdata: got %h want 0", mem_wdata); end
        rst = 1'b1;
        drive(EXE_NOP_OP, 32'h0, 32'h0, 1'b0);
        tick();
    endtask

    task automatic test_alu;
        exe_write_reg = 5'd9;
        drive(EXE_ADD_OP, 32'h7FFF_FFFF, 32'h1, 1'b1); #1;
        n_tests++; if (mem_wdata !== 32'h8000_0000) begin n_fail++; $display("FAIL add_wrap: got %h want 80000000", mem_wdata); end
        n_tests++; if (mem_we !== 1'b1) begin n_fail++; $display("FAIL add_we: got %b want 1", mem_we); end
        n_tests++; if (mem_write_reg !== 5'd9) begin n_fail++; $display("FAIL write_reg: got %0d want 9", mem_write_reg); end
        drive(EXE_SLT_OP, 32'hFFFF_FFFF, 32'h1, 1'b1); #1;
        n_tests++; if (mem_wdata !== 32'h1) begin n_fail++; $display("FAIL slt: got %h want 1", mem_wdata); end
        drive(EXE_SLTU_OP, 32'hFFFF_FFFF, 32'h1, 1'b1); #1;
        n_tests++; if (mem_wdata !== 32'h0) begin n_fail++; $display("FAIL sltu: got %h want 0", mem_wdata); end
        drive(EXE_SUB_OP, 32'h0, 32'h1, 1'b1); #1;
        n_tests++; if (mem_wdata !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL sub_wrap: got %h want ffffffff", mem_wdata); end
        exe_inst = 32'd4 << 6;
        drive(EXE_SRA_OP, 32'h0, 32'h8000_0000, 1'b1); #1;
        n_tests++; if (mem_wdata !== 32'hF800_0000) begin n_fail++; $display("FAIL sra: got %h want f8000000", mem_wdata); end
        drive(EXE_SRL_OP, 32'h0, 32'h8000_0000, 1'b1); #1;
        n_tests++; if (mem_wdata !== 32'h0800_0000) begin n_fail++; $display("FAIL srl: got %h want 08000000", mem_wdata); end
        drive(EXE_SLLV_OP, 32'h0000_0023, 32'h1, 1'b1); #1;
        n_tests++; if (mem_wdata !== 32'h8) begin n_fail++; $display("FAIL sllv: got %h want 8", mem_wdata); end
        drive(EXE_LUI_OP, 32'h0, 32'hFFFF_1234, 1'b1); #1;
        n_tests++; if (mem_wdata !== 32'h1234_0000) begin n_fail++; $display("FAIL lui: got %h want 12340000", mem_wdata); end
        drive(6'h3F, 32'h5, 32'h6, 1'b1); #1;
        n_tests++; if (mem_wdata !== 32'h0 || mem_we !== 1'b0) begin n_fail++; $display("FAIL unknown_op: got %h/%b want 0/0", mem_wdata, mem_we); end
        exe_inst = 32'h0;
        drive(EXE_NOP_OP, 32'h0, 32'h0, 1'b0);
        tick();
    endtask

    task automatic test_mult;
        drive(EXE_MULT_OP, 32'hFFFF_FFFF, 32'h2, 1'b1); #1;
        n_tests++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL mult_we: got %b want 0", mem_we); end
        tick();
        n_tests++; if (hi_o !== 32'hFFFF_FFFF || lo_o !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL mult: got %h_%h want ffffffff_fffffffe", hi_o, lo_o); end
        drive(EXE_MFLO_OP, 32'h0, 32'h0, 1'b1); #1;
        n_tests++; if (mem_wdata !== 32'hFFFF_FFFE || mem_we !== 1'b1) begin n_fail++; $display("FAIL mflo: got %h/%b want fffffffe/1", mem_wdata, mem_we); end
        drive(EXE_MULTU_OP, 32'hFFFF_FFFF, 32'h2, 1'b1);
        tick();
        n_tests++; if (hi_o !== 32'h1 || lo_o !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL multu: got %h_%h want 00000001_fffffffe", hi_o, lo_o); end
        drive(EXE_NOP_OP, 32'h0, 32'h0, 1'b0);
        tick();
    endtask

    task automatic test_link_hilo;
        exe_link_addr = 32'h0040_0008;
        drive(EXE_JAL_OP, 32'h0, 32'h0, 1'b1); #1;
        n_tests++; if (mem_wdata !== 32'h0040_0008) begin n_fail++; $display("FAIL jal: got %h want 00400008", mem_wdata); end
        drive(EXE_MTHI_OP, 32'h1234, 32'h0, 1'b0); #1;
        n_tests++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL mthi_we: got %b want 0", mem_we); end
        tick();
        drive(EXE_MFHI_OP, 32'h0, 32'h0, 1'b1); #1;
        n_tests++; if (mem_wdata !== 32'h1234) begin n_fail++; $display("FAIL mfhi: got %h want 1234", mem_wdata); end
        drive(EXE_MTLO_OP, 32'h5678, 32'h0, 1'b0);
        tick();
        n_tests++; if (lo_o !== 32'h5678 || hi_o !== 32'h1234) begin n_fail++; $display("FAIL mtlo: got %h_%h want 00001234_00005678", hi_o, lo_o); end
        drive(EXE_NOP_OP, 32'h0, 32'h0, 1'b0);
        tick();
    endtask

`ifdef EXE_DIV_EN
    // Leaves the bench in the first non-stalled cycle; cyc counts stalled cycles (capped).
    task automatic do_div(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int cyc);
        drive(op, a, b, 1'b1); #1;
        cyc = 0;
        while (stall_req === 1'b1 && cyc < 100) begin
            cyc++;
            @(posedge clk); #1;
            drive(EXE_NOP_OP, 32'h0, 32'h0, 1'b0); #1;
        end
    endtask

    task automatic test_div;
        int cyc;
        drive(EXE_MTLO_OP, 32'hA5A5, 32'h0, 1'b0);
        tick();
        do_div(EXE_DIV_OP, 32'hFFFF_FFF9, 32'h2, cyc);
        n_tests++; if (cyc !== 33) begin n_fail++; $display("FAIL div_stall_len: got %0d want 33", cyc); end
        n_tests++; if (lo_o !== 32'hA5A5 || mem_we !== 1'b0) begin n_fail++; $display("FAIL div_early: got %h/%b want 0000a5a5/0", lo_o, mem_we); end
        tick();
        n_tests++; if (lo_o !== 32'hFFFF_FFFD || hi_o !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL div_signed: got %h_%h want ffffffff_fffffffd", hi_o, lo_o); end
        do_div(EXE_DIVU_OP, 32'h7, 32'h2, cyc);
        tick();
        n_tests++; if (lo_o !== 32'h3 || hi_o !== 32'h1) begin n_fail++; $display("FAIL divu: got %h_%h want 00000001_00000003", hi_o, lo_o); end
        do_div(EXE_DIVU_OP, 32'h5, 32'h0, cyc);
        n_tests++; if (cyc !== 33) begin n_fail++; $display("FAIL div0_stall_len: got %0d want 33", cyc); end
        tick();
        n_tests++; if (lo_o !== 32'hFFFF_FFFF || hi_o !== 32'h5) begin n_fail++; $display("FAIL div0: got %h_%h want 00000005_ffffffff", hi_o, lo_o); end
        do_div(EXE_DIV_OP, 32'h8000_0000, 32'hFFFF_FFFF, cyc);
        tick();
        n_tests++; if (lo_o !== 32'h8000_0000 || hi_o !== 32'h0) begin n_fail++; $display("FAIL div_ovf: got %h_%h want 00000000_80000000", hi_o, lo_o); end
    endtask

    task automatic test_reset_mid_div;
        int cyc;
        drive(EXE_MTHI_OP, 32'hABCD, 32'h0, 1'b0);
        tick();
        drive(EXE_DIV_OP, 32'd100, 32'd7, 1'b0);
        tick();
        drive(EXE_NOP_OP, 32'h0, 32'h0, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        n_tests++; if (stall_req !== 1'b1) begin n_fail++; $display("FAIL busy_before_rst: got %b want 1", stall_req); end
        rst = 1'b0; #1;
        n_tests++; if (stall_req !== 1'b0 || hi_o !== 32'h0 || lo_o !== 32'h0) begin n_fail++; $display("FAIL mid_rst: got %b %h_%h want 0 0_0", stall_req, hi_o, lo_o); end
        tick();
        rst = 1'b1;
        tick();
        do_div(EXE_DIV_OP, 32'd6, 32'd3, cyc);
        n_tests++; if (cyc !== 33) begin n_fail++; $display("FAIL post_rst_stall_len: got %0d want 33", cyc); end
        tick();
        n_tests++; if (lo_o !== 32'h2 || hi_o !== 32'h0) begin n_fail++; $display("FAIL post_rst_div: got %h_%h want 00000000_00000002", hi_o, lo_o); end
    endtask
`else
    task automatic test_div_disabled;
        drive(EXE_MTHI_OP, 32'h55, 32'h0, 1'b0);
        tick();
        drive(EXE_MTLO_OP, 32'h66, 32'h0, 1'b0);
        tick();
        drive(EXE_DIVU_OP, 32'h7, 32'h2, 1'b1); #1;
        n_tests++; if (stall_req !== 1'b0 || mem_we !== 1'b0) begin n_fail++; $display("FAIL div_nop: got stall %b we %b want 0 0", stall_req, mem_we); end
        tick();
        n_tests++; if (hi_o !== 32'h55 || lo_o !== 32'h66) begin n_fail++; $display("FAIL div_nop_hilo: got %h_%h want 00000055_00000066", hi_o, lo_o); end
        drive(EXE_NOP_OP, 32'h0, 32'h0, 1'b0);
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_alu();
        test_mult();
        test_link_hilo();
`ifdef EXE_DIV_EN
        test_div();
        test_reset_mid_div();
`else
        test_div_disabled();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
